// File: rtl/ballot_pkg.sv
// Shared types and sizing helpers for the ballot input front end.
// No logic of its own; imported by the debouncer and the controller.
package ballot_pkg;

    localparam int NUM_CANDIDATES = 4;

    localparam int DEBOUNCE_CYCLES_DEF = 16;
    localparam int LOCKOUT_CYCLES_DEF  = 1000;

    typedef enum logic [1:0] {
        IDLE         = 2'd0,
        LOCKOUT      = 2'd1,
        WAIT_RELEASE = 2'd2
    } ballot_state_e;

    // Bits needed to hold values 0..n-1, never less than one bit.
    function automatic int cnt_width(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

    localparam int DB_CNT_W_DEF   = cnt_width(DEBOUNCE_CYCLES_DEF);
    localparam int LOCK_CNT_W_DEF = cnt_width(LOCKOUT_CYCLES_DEF);

endpackage

// File: rtl/button_debouncer.sv
// One raw button: 2-flop sync, DEBOUNCE_CYCLES-stable filter, registered rise pulse.
// Level settles DEBOUNCE_CYCLES+2 edges after a raw step; rise pulse one edge later.
module button_debouncer
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level_out,
    output logic rise_pulse
);

    localparam int               CNT_W    = cnt_width(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync2_q;
    logic             stable_q, stable_d;
    logic             prev_q;
    logic             rise_q;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    // Counter only runs while the synced input disagrees with the filtered level.
    always_comb begin
        stable_d = stable_q;
        cnt_d    = '0;
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = sync2_q;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            prev_q   <= 1'b0;
            rise_q   <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= raw_in;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            prev_q   <= stable_q;
            rise_q   <= stable_q & ~prev_q;
            cnt_q    <= cnt_d;
        end
    end

    assign level_out  = stable_q;
    assign rise_pulse = rise_q;

endmodule

// File: rtl/ballot_input_ctrl.sv
// Four debounced candidate buttons -> at most one registered vote pulse per voter, then lockout and release-all.
// No backpressure: mode=1 gates voting and drops presses; BALLOT_REJECT_COUNT_EN adds reject_count.
module ballot_input_ctrl
    import ballot_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int LOCKOUT_CYCLES  = LOCKOUT_CYCLES_DEF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       mode,
    input  logic       button1,
    input  logic       button2,
    input  logic       button3,
    input  logic       button4,
    output logic       cand1_vote_valid,
    output logic       cand2_vote_valid,
    output logic       cand3_vote_valid,
    output logic       cand4_vote_valid,
    output logic       ready
`ifdef BALLOT_REJECT_COUNT_EN
    ,
    output logic [7:0] reject_count
`endif
);

    localparam int                LOCK_W    = cnt_width(LOCKOUT_CYCLES);
    localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);

    logic [NUM_CANDIDATES-1:0] btn_raw;
    logic [NUM_CANDIDATES-1:0] level;
    logic [NUM_CANDIDATES-1:0] rise;
    logic                      press_one;

    ballot_state_e             state_q, state_d;
    logic [LOCK_W-1:0]         lock_q, lock_d;
    logic [NUM_CANDIDATES-1:0] vote_q, vote_d;

    assign btn_raw = {button4, button3, button2, button1};

    for (genvar i = 0; i < NUM_CANDIDATES; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clk       (clk),
            .reset     (reset),
            .raw_in    (btn_raw[i]),
            .level_out (level[i]),
            .rise_pulse(rise[i])
        );
    end

    assign press_one = $onehot(rise);

    always_comb begin
        state_d = state_q;
        lock_d  = lock_q;
        vote_d  = '0;
        if (mode) begin
            state_d = IDLE;
            lock_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    // Simultaneous presses are ambiguous and fall through unaccepted.
                    if (press_one) begin
                        vote_d  = rise;
                        lock_d  = LOCK_LOAD;
                        state_d = LOCKOUT;
                    end
                end
                LOCKOUT: begin
                    if (lock_q == '0) begin
                        state_d = WAIT_RELEASE;
                    end else begin
                        lock_d = lock_q - LOCK_W'(1);
                    end
                end
                WAIT_RELEASE: begin
                    if (level == '0) begin
                        state_d = IDLE;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            vote_q  <= '0;
        end else begin
            state_q <= state_d;
            lock_q  <= lock_d;
            vote_q  <= vote_d;
        end
    end

    assign cand1_vote_valid = vote_q[0];
    assign cand2_vote_valid = vote_q[1];
    assign cand3_vote_valid = vote_q[2];
    assign cand4_vote_valid = vote_q[3];
    assign ready            = reset && !mode && (state_q == IDLE);

`ifdef BALLOT_REJECT_COUNT_EN
    logic       press_multi;
    logic [7:0] rej_q, rej_d;

    assign press_multi = !$onehot0(rise);

    always_comb begin
        rej_d = rej_q;
        if (!mode && (state_q == IDLE) && press_multi && (rej_q != 8'hFF)) begin
            rej_d = rej_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            rej_q <= '0;
        end else begin
            rej_q <= rej_d;
        end
    end

    assign reject_count = rej_q;
`endif

endmodule

// File: tb/tb_ballot_input_ctrl.sv
// Directed bench for ballot_input_ctrl with DEBOUNCE_CYCLES=4, LOCKOUT_CYCLES=8.
// Stimulus pushes expected pulses (candidate, cycle); a negedge monitor pops and compares.
module tb_ballot_input_ctrl;

    localparam int DB  = 4;
    localparam int LK  = 8;
    localparam int LAT = DB + 4;  // step at negedge cyc N -> pulse seen at negedge cyc N+LAT

    logic clk = 1'b0;
    logic reset, mode;
    logic button1, button2, button3, button4;
    logic cand1_vote_valid, cand2_vote_valid, cand3_vote_valid, cand4_vote_valid;
    logic ready;
`ifdef BALLOT_REJECT_COUNT_EN
    logic [7:0] reject_count;
`endif

    ballot_input_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .LOCKOUT_CYCLES (LK)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .mode            (mode),
        .button1         (button1),
        .button2         (button2),
        .button3         (button3),
        .button4         (button4),
        .cand1_vote_valid(cand1_vote_valid),
        .cand2_vote_valid(cand2_vote_valid),
        .cand3_vote_valid(cand3_vote_valid),
        .cand4_vote_valid(cand4_vote_valid),
        .ready           (ready)
`ifdef BALLOT_REJECT_COUNT_EN
        ,
        .reject_count    (reject_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int cand;
        int cyc;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic expect_pulse(input int cand, input int at);
        exp_t e;
        e.cand = cand;
        e.cyc  = at;
        exp_q.push_back(e);
    endtask

    task automatic wait_to(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic chk_ready(input string name, input int exp);
        #1 chk(name, int'(ready), exp);
    endtask

    logic [3:0] vld;
    assign vld = {cand4_vote_valid, cand3_vote_valid, cand2_vote_valid, cand1_vote_valid};

    always @(negedge clk) begin : monitor
        exp_t e;
        int   c;
        if (vld != 4'b0000) begin
            case (vld)
                4'b0001: c = 1;
                4'b0010: c = 2;
                4'b0100: c = 3;
                4'b1000: c = 4;
                default: c = 99;
            endcase
            if (exp_q.size() == 0) begin
                chk("unexpected_pulse", c, 0);
            end else begin
                e = exp_q.pop_front();
                chk("pulse_cand", c, e.cand);
                chk("pulse_cycle", cyc, e.cyc);
            end
        end
    end

    initial begin
        int s;
        reset   = 1'b0;
        mode    = 1'b0;
        button1 = 1'b0;
        button2 = 1'b0;
        button3 = 1'b0;
        button4 = 1'b0;

        // Reset behaviour
        repeat (3) @(negedge clk);
        chk_ready("ready_in_reset", 0);
        chk("vld_in_reset", int'(vld), 0);
`ifdef BALLOT_REJECT_COUNT_EN
        chk("reject_after_reset", int'(reject_count), 0);
`endif
        @(negedge clk);
        reset = 1'b1;
        chk_ready("ready_after_reset", 1);
        repeat (4) @(negedge clk);

        // Clean press on button2, held 20 cycles
        s = cyc;
        button2 = 1'b1;
        expect_pulse(2, s + LAT);
        wait_to(s + 10);
        chk_ready("clean_ready_lockout", 0);
        wait_to(s + 19);
        chk_ready("clean_ready_held", 0);
        wait_to(s + 20);
        button2 = 1'b0;
        wait_to(s + 26);
        chk_ready("clean_ready_before_rel", 0);
        wait_to(s + 27);
        chk_ready("clean_ready_after_rel", 1);
        wait_to(s + 30);

        // Bouncing button1: five 2-cycle highs, then held
        for (int k = 0; k < 5; k++) begin
            button1 = 1'b1;
            repeat (2) @(negedge clk);
            button1 = 1'b0;
            repeat (2) @(negedge clk);
        end
        s = cyc;
        button1 = 1'b1;
        expect_pulse(1, s + LAT);
        wait_to(s + 12);
        button1 = 1'b0;
        wait_to(s + 22);
        chk_ready("bounce_ready_end", 1);

        // Simultaneous button3 + button4
        s = cyc;
        button3 = 1'b1;
        button4 = 1'b1;
        wait_to(s + 10);
        chk_ready("simul_ready", 1);
`ifdef BALLOT_REJECT_COUNT_EN
        chk("simul_reject_count", int'(reject_count), 1);
`endif
        button3 = 1'b0;
        button4 = 1'b0;
        wait_to(s + 20);

        // Lockout: button4 pressed while locked out is ignored
        s = cyc;
        button1 = 1'b1;
        expect_pulse(1, s + LAT);
        wait_to(s + 2);
        button4 = 1'b1;
        wait_to(s + 8);
        button4 = 1'b0;
        wait_to(s + 10);
        button1 = 1'b0;
        chk_ready("lock_ready_in_lockout", 0);
        wait_to(s + 16);
        chk_ready("lock_ready_end_lockout", 0);
        wait_to(s + 17);
        chk_ready("lock_ready_idle", 1);
        wait_to(s + 18);
        button4 = 1'b1;
        expect_pulse(4, s + 18 + LAT);
        wait_to(s + 30);
        button4 = 1'b0;
        wait_to(s + 38);
        chk_ready("lock_ready_after_b4", 1);

        // Mode gate: press while mode=1 is discarded, held press not replayed
        s = cyc;
        mode    = 1'b1;
        button2 = 1'b1;
        chk_ready("mode_ready_low", 0);
        wait_to(s + 12);
        mode = 1'b0;
        chk_ready("mode_ready_back", 1);
        wait_to(s + 20);
        button2 = 1'b0;
        wait_to(s + 28);
        button2 = 1'b1;
        expect_pulse(2, s + 28 + LAT);
        wait_to(s + 40);
        button2 = 1'b0;
        wait_to(s + 48);
        chk_ready("mode_ready_end", 1);

        // Reset during lockout clears it; next press accepted at once
        s = cyc;
        button3 = 1'b1;
        expect_pulse(3, s + LAT);
        wait_to(s + 5);
        button3 = 1'b0;
        wait_to(s + 8);
        reset = 1'b0;
        chk_ready("rst_ready_in_reset", 0);
        wait_to(s + 9);
        reset   = 1'b1;
        button1 = 1'b1;
        expect_pulse(1, s + 9 + LAT);
        chk_ready("rst_ready_after", 1);
        wait_to(s + 20);
        button1 = 1'b0;
        wait_to(s + 40);

        chk("pending_pulses", exp_q.size(), 0);
`ifdef BALLOT_REJECT_COUNT_EN
        chk("final_reject_count", int'(reject_count), 0);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
